// File: rtl/seq_det_param.sv
// Parametrised serial pattern detector with loadable pattern,
// overlap control and a saturating match counter.
module seq_det_param #(
   parameter int             LEN     = 3,
   parameter logic [LEN-1:0] PATTERN = 3'b001,
   parameter int             CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             x,
   input  logic             en,
   input  logic             overlap,
   input  logic             pat_ld,
   input  logic [LEN-1:0]   pat_in,
   input  logic             clr_cnt,
   output logic             y,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
);

   localparam int FW = $clog2(LEN + 1);

   logic [LEN-1:0]   pat;
   logic [LEN-1:0]   hist;
   logic [FW-1:0]    fill;
   logic [LEN-1:0]   hist_n;
   logic [FW-1:0]    fill_n;
   logic             match;
   logic [CNT_W-1:0] cnt_inc;

   always_comb begin
      hist_n  = {hist[LEN-2:0], x};
      fill_n  = (fill == FW'(LEN)) ? fill : fill + 1'b1;
      match   = !pat_ld && en && (fill_n == FW'(LEN)) && (hist_n == pat);
      cnt_inc = match_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pat       <= PATTERN;
         hist      <= '0;
         fill      <= '0;
         y         <= 1'b0;
         match_cnt <= '0;
         cnt_sat   <= 1'b0;
      end else begin
         if (pat_ld) begin
            pat  <= pat_in;
            fill <= '0;
            y    <= 1'b0;
         end else if (en) begin
            hist <= hist_n;
            y    <= match;
            // non-overlap mode throws the history away after a hit
            fill <= (match && !overlap) ? '0 : fill_n;
         end else begin
            y <= 1'b0;
         end

         if (clr_cnt) begin
            match_cnt <= match ? CNT_W'(1) : '0;
            cnt_sat   <= 1'b0;
         end else if (match && !(&match_cnt)) begin
            match_cnt <= cnt_inc;
            cnt_sat   <= &cnt_inc;
         end
      end
   end

endmodule

// File: tb/tb_seq_det_param.sv
// Directed bench for seq_det_param: default build plus a
// narrow-counter build sharing the same stimulus.
module tb_seq_det_param;

   logic       clk;
   logic       reset;
   logic       x;
   logic       en;
   logic       overlap;
   logic       pat_ld;
   logic [2:0] pat_in;
   logic       clr_cnt;
   logic       y;
   logic [7:0] match_cnt;
   logic       cnt_sat;
   logic       y2;
   logic [1:0] match_cnt2;
   logic       cnt_sat2;

   int nvec;
   int nerr;

   seq_det_param dut (
      .clk(clk), .reset(reset), .x(x), .en(en),
      .overlap(overlap), .pat_ld(pat_ld), .pat_in(pat_in),
      .clr_cnt(clr_cnt), .y(y), .match_cnt(match_cnt),
      .cnt_sat(cnt_sat)
   );

   seq_det_param #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .x(x), .en(en),
      .overlap(overlap), .pat_ld(pat_ld), .pat_in(pat_in),
      .clr_cnt(clr_cnt), .y(y2), .match_cnt(match_cnt2),
      .cnt_sat(cnt_sat2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sb(input logic b, input logic ey, input string tag);
      x  = b;
      en = 1'b1;
      tick();
      chk(tag, {31'd0, y}, {31'd0, ey});
   endtask

   task automatic hold(input logic b, input string tag);
      x  = b;
      en = 1'b0;
      tick();
      chk(tag, {31'd0, y}, 32'd0);
   endtask

   task automatic load(input logic [2:0] p, input logic clr);
      pat_ld  = 1'b1;
      pat_in  = p;
      clr_cnt = clr;
      en      = 1'b1;
      x       = 1'b1;
      tick();
      chk("ld_y", {31'd0, y}, 32'd0);
      pat_ld  = 1'b0;
      clr_cnt = 1'b0;
   endtask

   task automatic pulse_reset();
      #2 reset = 1'b0;
      #2 reset = 1'b1;
   endtask

   initial begin
      nvec    = 0;
      nerr    = 0;
      reset   = 1'b0;
      x       = 1'b0;
      en      = 1'b0;
      overlap = 1'b1;
      pat_ld  = 1'b0;
      pat_in  = 3'b000;
      clr_cnt = 1'b0;

      #12;
      chk("rst_y", {31'd0, y}, 32'd0);
      chk("rst_cnt", {24'd0, match_cnt}, 32'd0);
      chk("rst_sat", {31'd0, cnt_sat}, 32'd0);
      reset = 1'b1;

      // single 0 then 1: too few bits for a match
      sb(1'b0, 1'b0, "t1a_b0");
      sb(1'b1, 1'b0, "t1a_b1");
      pulse_reset();

      sb(1'b0, 1'b0, "t1_b0");
      sb(1'b0, 1'b0, "t1_b1");
      sb(1'b0, 1'b0, "t1_b2");
      sb(1'b1, 1'b1, "t1_b3");
      sb(1'b1, 1'b0, "t1_b4");
      chk("t1_cnt", {24'd0, match_cnt}, 32'd1);

      // 101 with overlap
      overlap = 1'b1;
      load(3'b101, 1'b1);
      sb(1'b1, 1'b0, "t2o_b0");
      sb(1'b0, 1'b0, "t2o_b1");
      sb(1'b1, 1'b1, "t2o_b2");
      sb(1'b0, 1'b0, "t2o_b3");
      sb(1'b1, 1'b1, "t2o_b4");
      chk("t2o_cnt", {24'd0, match_cnt}, 32'd2);

      // 101 without overlap
      overlap = 1'b0;
      load(3'b101, 1'b1);
      sb(1'b1, 1'b0, "t2n_b0");
      sb(1'b0, 1'b0, "t2n_b1");
      sb(1'b1, 1'b1, "t2n_b2");
      sb(1'b0, 1'b0, "t2n_b3");
      sb(1'b1, 1'b0, "t2n_b4");
      chk("t2n_cnt", {24'd0, match_cnt}, 32'd1);

      // en gating
      overlap = 1'b1;
      load(3'b001, 1'b1);
      sb(1'b0, 1'b0, "t3_b0");
      hold(1'b1, "t3_h0");
      hold(1'b1, "t3_h1");
      hold(1'b1, "t3_h2");
      sb(1'b0, 1'b0, "t3_b1");
      sb(1'b1, 1'b1, "t3_b2");
      chk("t3_cnt", {24'd0, match_cnt}, 32'd1);

      // pat_ld mid-stream
      pulse_reset();
      sb(1'b0, 1'b0, "t4_b0");
      sb(1'b0, 1'b0, "t4_b1");
      load(3'b110, 1'b0);
      sb(1'b1, 1'b0, "t4_b2");
      sb(1'b1, 1'b0, "t4_b3");
      sb(1'b0, 1'b1, "t4_b4");

      // narrow counter saturation
      pulse_reset();
      overlap = 1'b1;
      load(3'b111, 1'b0);
      sb(1'b1, 1'b0, "t5_b0");
      sb(1'b1, 1'b0, "t5_b1");
      sb(1'b1, 1'b1, "t5_m1");
      chk("t5_c1", {30'd0, match_cnt2}, 32'd1);
      chk("t5_s1", {31'd0, cnt_sat2}, 32'd0);
      sb(1'b1, 1'b1, "t5_m2");
      chk("t5_c2", {30'd0, match_cnt2}, 32'd2);
      chk("t5_s2", {31'd0, cnt_sat2}, 32'd0);
      sb(1'b1, 1'b1, "t5_m3");
      chk("t5_c3", {30'd0, match_cnt2}, 32'd3);
      chk("t5_s3", {31'd0, cnt_sat2}, 32'd1);
      sb(1'b1, 1'b1, "t5_m4");
      chk("t5_c4", {30'd0, match_cnt2}, 32'd3);
      chk("t5_s4", {31'd0, cnt_sat2}, 32'd1);
      chk("t5_y2", {31'd0, y2}, 32'd1);
      chk("t5_cw", {24'd0, match_cnt}, 32'd4);
      clr_cnt = 1'b1;
      sb(1'b1, 1'b1, "t5_m5");
      clr_cnt = 1'b0;
      chk("t5_c5", {30'd0, match_cnt2}, 32'd1);
      chk("t5_s5", {31'd0, cnt_sat2}, 32'd0);
      chk("t5_cw5", {24'd0, match_cnt}, 32'd1);

      // async reset while y is high
      load(3'b100, 1'b0);
      sb(1'b1, 1'b0, "t6_b0");
      sb(1'b0, 1'b0, "t6_b1");
      sb(1'b0, 1'b1, "t6_b2");
      #2 reset = 1'b0;
      #1;
      chk("t6_y", {31'd0, y}, 32'd0);
      chk("t6_cnt", {24'd0, match_cnt}, 32'd0);
      chk("t6_sat", {31'd0, cnt_sat}, 32'd0);
      chk("t6_cnt2", {30'd0, match_cnt2}, 32'd0);
      #1 reset = 1'b1;
      sb(1'b1, 1'b0, "t6_r0");
      sb(1'b0, 1'b0, "t6_r1");
      sb(1'b0, 1'b0, "t6_r2");
      sb(1'b1, 1'b1, "t6_r3");
      chk("t6_rcnt", {24'd0, match_cnt}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
